esn_readout: RTL
================

// Module: esn_readout
// PURPOSE
//  Linear readout stage downstream of the reservoir: y = sum_i W[i] * x[i] over the packed reservoir
//  state (x[i] = iState[i*DATA_WIDTH +: DATA_WIDTH], unsigned). Weights are signed, held in a local
//  register file and loaded through a write port. Captures one state snapshot per request and computes
//  one neuron per cycle with a single multiply-accumulate. Produces one signed output per request.
// PARAMETERS
//  RESERVOIR_SIZE  3   neuron count; matches the reservoir's reservoir_size
//  DATA_WIDTH      3   bits per neuron state; matches the reservoir's data_width
//  WEIGHT_WIDTH    8   signed readout weight width
//  OUT_WIDTH       16  signed output width
// PORTS
//  iClk      in   1                          clock; all logic on rising edge
//  iRst      in   1                          synchronous reset, active-high
//  iValid    in   1                          request: capture iState and start a readout
//  iState    in   RESERVOIR_SIZE*DATA_WIDTH  packed reservoir state, neuron 0 in LSBs
//  iWWr      in   1                          weight write strobe
//  iWAddr    in   $clog2(RESERVOIR_SIZE)     weight index
//  iWData    in   WEIGHT_WIDTH               signed weight value
//  oBusy     out  1                          high from accept until oValid cycle inclusive
//  oValid    out  1                          one-cycle pulse, oY valid
//  oY        out  OUT_WIDTH                  signed result, held until next oValid
// BEHAVIOUR
//  - Reset: FSM->IDLE, all weights 0, accumulator 0, index 0, oBusy=0, oValid=0, oY=0.
//  - FSM: IDLE -(iValid)-> ACC -(index==RESERVOIR_SIZE-1 processed)-> DONE -> IDLE.
//  - IDLE: iValid=1 latches full iState into snapshot reg, clears acc, index=0, oBusy=1 next cycle.
//  - ACC: each cycle acc += $signed(W[idx]) * $signed({1'b0,x_snap[idx]}); idx++. RESERVOIR_SIZE cycles.
//  - DONE: oY <= final acc (see CONFIGURATION), oValid=1 for exactly this cycle; oBusy still 1.
//  - Latency: iValid sampled at edge t -> oValid high in cycle t+RESERVOIR_SIZE+1; throughput one
//    request per RESERVOIR_SIZE+2 cycles; new iValid accepted in the cycle after oValid.
//  - iValid while oBusy=1: ignored, no queueing. iState changes while busy do not affect the result.
//  - Acc width ACC_W = WEIGHT_WIDTH+DATA_WIDTH+1+$clog2(RESERVOIR_SIZE); no overflow possible inside.
//  - Weight write: applied at edge when iWWr=1 and oBusy=0; ignored when oBusy=1 or iWAddr>=RESERVOIR_SIZE.
//    Write and iValid in the same IDLE cycle: write lands, computation uses the new weight.
//  - iRst mid-operation: abort; no oValid issued; weights cleared; FSM IDLE next cycle.
// CONFIGURATION
//  ESN_READOUT_SAT_EN defined: oY = acc clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  Not defined: oY = acc[OUT_WIDTH-1:0] (two's-complement wrap); if OUT_WIDTH>=ACC_W, sign-extend.
// STRUCTURE
//  - Package esn_pkg: FSM state enum (IDLE/ACC/DONE), ACC_W width function, shared clog2 helper,
//    state-slice extraction function used by reservoir consumers.
//  - One sub-module esn_mac: registered signed multiply-accumulate with clear and enable.
//  - Top holds weight regfile, snapshot reg, index counter, FSM, output clamp/truncate.
// TESTING (defaults, OUT_WIDTH=16 unless stated)
//  1. Reset, no writes, iValid with x={7,5,3} -> oValid at t+4, oY=0; oBusy high cycles t+1..t+4.
//  2. W={1,2,3}, x0=3,x1=5,x2=7 -> oY=34 at t+4; iState changed at t+1 -> still 34.
//  3. W all -128, x all 7 -> oY=-2688; W={127,-128,0}, x={7,7,7} -> oY=-7.
//  4. OUT_WIDTH=8, W all 127, x all 7 (sum 2667): with ESN_READOUT_SAT_EN -> 127; without -> 107.
//  5. iValid held 6 cycles -> exactly one oValid at t+4, second accept at t+5, oValid at t+9;
//     iWWr during busy -> weight unchanged; iWAddr=3 -> ignored.
//  6. iRst at t+2 of a readout -> no oValid, oBusy=0 next cycle; subsequent readout gives oY=0.

Source files
------------

// File: rtl/esn_pkg.sv
// +----------------------------------------------------------------------------+
// | esn_pkg : shared types and helpers for the ESN readout and other reservoir  |
// |           consumers (FSM states, accumulator sizing, state-slice access).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package esn_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int C_MAX_STATE_W = 1024;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int acc_width(input int ww, input int dw, input int rs);
      return ww + dw + 1 + clog2(rs);
   endfunction

   // Neuron idx of a packed state vector (neuron 0 in LSBs), zero-extended.
   function automatic logic [31:0] state_slice(input logic [C_MAX_STATE_W-1:0] state,
                                               input int idx, input int dw);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < dw) begin
            r[b] = state[idx*dw + b];
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/esn_mac.sv
// +----------------------------------------------------------------------------+
// | esn_mac : registered signed-weight x unsigned-state multiply-accumulate     |
// |           with synchronous clear and enable; exposes the next-state sum.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module esn_mac #(
   parameter int A_W   = 8,
   parameter int B_W   = 3,
   parameter int ACC_W = 14
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [A_W-1:0]   a_i,
   input  logic        [B_W-1:0]   b_i,
   output logic signed [ACC_W-1:0] acc_d_o
);

   localparam int PROD_W = A_W + B_W + 1;

   logic signed [PROD_W-1:0] prod_w;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   always_comb begin
      // State operand is unsigned: widen with a zero MSB before the signed multiply.
      prod_w = PROD_W'(a_i) * PROD_W'($signed({1'b0, b_i}));
      acc_d  = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod_w);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_d_o = acc_d;

endmodule

`default_nettype wire

// File: rtl/esn_readout.sv
// +----------------------------------------------------------------------------+
// | esn_readout : linear ESN readout y = sum W[i]*x[i], one neuron per cycle.   |
// |   Optional macro ESN_READOUT_SAT_EN: saturate oY instead of wrapping.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module esn_readout
   import esn_pkg::*;
#(
   parameter int RESERVOIR_SIZE = 3,
   parameter int DATA_WIDTH     = 3,
   parameter int WEIGHT_WIDTH   = 8,
   parameter int OUT_WIDTH      = 16
) (
   input  logic                                 iClk,
   input  logic                                 iRst,
   input  logic                                 iValid,
   input  logic [RESERVOIR_SIZE*DATA_WIDTH-1:0] iState,
   input  logic                                 iWWr,
   input  logic [$clog2(RESERVOIR_SIZE)-1:0]    iWAddr,
   input  logic [WEIGHT_WIDTH-1:0]              iWData,
   output logic                                 oBusy,
   output logic                                 oValid,
   output logic [OUT_WIDTH-1:0]                 oY
);

   localparam int ADDR_W = clog2(RESERVOIR_SIZE);
   localparam int ACC_W  = acc_width(WEIGHT_WIDTH, DATA_WIDTH, RESERVOIR_SIZE);
   localparam int WIDE_W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
   localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(RESERVOIR_SIZE - 1);

   state_e                               state_q;
   logic [ADDR_W-1:0]                    idx_q;
   logic [RESERVOIR_SIZE*DATA_WIDTH-1:0] snap_q;
   logic signed [WEIGHT_WIDTH-1:0]       w_q [RESERVOIR_SIZE];
   logic                                 busy_q;
   logic                                 valid_q;
   logic [OUT_WIDTH-1:0]                 y_q;

   logic                                 start_w;
   logic                                 acc_en_w;
   logic signed [WEIGHT_WIDTH-1:0]       weight_w;
   logic [DATA_WIDTH-1:0]                x_w;
   logic signed [ACC_W-1:0]              acc_d;
   logic signed [WIDE_W-1:0]             acc_wide_w;
   logic [OUT_WIDTH-1:0]                 y_d;

   assign start_w    = (state_q == S_IDLE) && iValid;
   assign acc_en_w   = (state_q == S_ACC);
   assign weight_w   = w_q[idx_q];
   assign x_w        = DATA_WIDTH'(state_slice(C_MAX_STATE_W'(snap_q), 32'(idx_q), DATA_WIDTH));
   assign acc_wide_w = WIDE_W'(acc_d);

   esn_mac #(
      .A_W   (WEIGHT_WIDTH),
      .B_W   (DATA_WIDTH),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .clr_i   (start_w),
      .en_i    (acc_en_w),
      .a_i     (weight_w),
      .b_i     (x_w),
      .acc_d_o (acc_d)
   );

`ifdef ESN_READOUT_SAT_EN
   localparam logic signed [WIDE_W-1:0] C_Y_MAX =
      {{(WIDE_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] C_Y_MIN =
      {{(WIDE_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   always_comb begin
      y_d = acc_wide_w[OUT_WIDTH-1:0];
      if (acc_wide_w > C_Y_MAX) begin
         y_d = C_Y_MAX[OUT_WIDTH-1:0];
      end else if (acc_wide_w < C_Y_MIN) begin
         y_d = C_Y_MIN[OUT_WIDTH-1:0];
      end
   end
`else
   // acc_wide_w is already sign-extended, so this covers both wrap and extend.
   assign y_d = acc_wide_w[OUT_WIDTH-1:0];
`endif

   // Writes are locked out for the whole busy window so a readout sees stable weights.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i < RESERVOIR_SIZE; i++) begin
            w_q[i] <= '0;
         end
      end else if (iWWr && !busy_q && (32'(iWAddr) < RESERVOIR_SIZE)) begin
         w_q[iWAddr] <= iWData;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         snap_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iValid) begin
                  snap_q  <= iState;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ACC;
               end
            end
            S_ACC: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == C_LAST_IDX) begin
                  idx_q   <= '0;
                  y_q     <= y_d;
                  valid_q <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oBusy  = busy_q;
   assign oValid = valid_q;
   assign oY     = y_q;

endmodule

`default_nettype wire
